// File: rtl/ram_pkg.sv
// Shared definitions for the simple-dual-port RAM: FSM state encoding and
// default geometry constants used by the datapath.
package ram_pkg;

  localparam int unsigned RAM_DW = 8;
  localparam int unsigned RAM_AW = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps zero writes across every word after reset or on a
// clr request, and holds busy high for exactly DEPTH cycles.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned AW    = RAM_AW,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr
);

  // One extra pointer bit so DEPTH == 2**AW is representable without wrap.
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  ram_state_e  state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clear_we = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clear_we = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy       = (state_q == ST_CLEAR);
  assign clear_addr = ptr_q[AW-1:0];

endmodule

// File: rtl/ram_sync_dp.sv
// Simple-dual-port RAM with registered read and built-in clear sweep.
// Define RAM_BYPASS_EN for write-first same-address read-during-write;
// otherwise the read returns the old contents (read-first).
module ram_sync_dp
  import ram_pkg::*;
#(
  parameter int unsigned DW    = RAM_DW,
  parameter int unsigned AW    = RAM_AW,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd,
  output logic          rvalid,
  output logic          busy
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic [DW-1:0] rd_q, rd_d;
  logic          rvalid_q, rvalid_d;

  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic          wa_ok, ra_ok;

  ram_clear_seq #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .busy       (busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  assign wa_ok = ({1'b0, wa} < DEPTH_L);
  assign ra_ok = ({1'b0, ra} < DEPTH_L);

  // Sweep owns the single array write port while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wa;
    mem_wdata = wd;
    if (clear_we) begin
      mem_we    = 1'b1;
      mem_waddr = clear_addr;
      mem_wdata = '0;
    end else if (!busy && we && wa_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_d     = rd_q;
    rvalid_d = 1'b0;
    if (!busy && re) begin
      rvalid_d = 1'b1;
      if (!ra_ok) begin
        rd_d = '0;
      end else begin
        rd_d = mem_q[ra];
`ifdef RAM_BYPASS_EN
        if (we && wa_ok && (wa == ra)) begin
          rd_d = wd;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rd     = rd_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_sync_dp.sv
// Self-checking bench for ram_sync_dp: a 16-word and a 12-word instance
// share stimulus; directed vector table plus clear/reset sequences.
module tb_ram_sync_dp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, we, re;
  logic [3:0] wa, ra;
  logic [7:0] wd;
  logic [7:0] rd, rd12;
  logic       rvalid, rvalid12, busy, busy12;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_sync_dp #(.DW(8), .AW(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd), .rvalid(rvalid), .busy(busy)
  );

  ram_sync_dp #(.DW(8), .AW(4), .DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd12), .rvalid(rvalid12), .busy(busy12)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       exp_rv;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [3:0] a_w,
                       input logic [7:0] d, input logic r, input logic [3:0] a_r);
    clr = c; we = w; wa = a_w; wd = d; re = r; ra = a_r;
  endtask

  // Counts edges until each instance drops busy; 0 means it never dropped.
  task automatic measure_busy(output int c16, output int c12);
    c16 = 0;
    c12 = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (!busy && c16 == 0) c16 = c;
      if (!busy12 && c12 == 0) c12 = c;
      if (c16 != 0 && c12 != 0) break;
    end
  endtask

  initial begin
    int c16, c12, cnt;
    logic [7:0] rdw_exp;

`ifdef RAM_BYPASS_EN
    rdw_exp = 8'h3C;
`else
    rdw_exp = 8'h11;
`endif
    vt[0]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0,  1'b1, 8'h00};
    vt[1]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b1, 8'h00};
    vt[2]  = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0,  1'b0, 8'h00};
    vt[3]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3,  1'b1, 8'hA5};
    vt[4]  = '{1'b1, 4'd9, 8'h5A, 1'b1, 4'd3,  1'b1, 8'hA5};
    vt[5]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd9,  1'b1, 8'h5A};
    vt[6]  = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0,  1'b0, 8'h5A};
    vt[7]  = '{1'b1, 4'd5, 8'h11, 1'b0, 4'd0,  1'b0, 8'h5A};
    vt[8]  = '{1'b1, 4'd5, 8'h3C, 1'b1, 4'd5,  1'b1, rdw_exp};
    vt[9]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5,  1'b1, 8'h3C};
    vt[10] = '{1'b1, 4'd0, 8'hC3, 1'b1, 4'd15, 1'b1, 8'h00};
    vt[11] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0,  1'b1, 8'hC3};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("reset_busy", 32'(busy), 1);
    chk("reset_rvalid", 32'(rvalid), 0);
    chk("reset_rd", 32'(rd), 0);
    chk("reset_busy12", 32'(busy12), 1);

    // Initial sweep length and cleared contents
    rst_n = 1'b1;
    measure_busy(c16, c12);
    chk("init_sweep_16", 32'(c16), 16);
    chk("init_sweep_12", 32'(c12), 12);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 1, 4'(i));
      step();
      chk($sformatf("cleared_rd[%0d]", i), {23'd0, rvalid, rd}, {23'd0, 1'b1, 8'h00});
    end

    for (int i = 0; i < 12; i++) begin
      drive(0, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra);
      step();
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vt[i].exp_rv));
      chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vt[i].exp_rd));
    end

    // CLR sweep with writes attempted throughout
    drive(0, 1, 7, 8'hFF, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 7);
    step();
    chk("pre_clr_rd7", 32'(rd), 32'hFF);
    drive(1, 1, 2, 8'h77, 1, 7);
    step();
    chk("clr_cycle_read", {23'd0, rvalid, rd}, {23'd0, 1'b1, 8'hFF});
    chk("clr_busy_rise", 32'(busy), 1);
    drive(0, 1, 7, 8'hEE, 1, 7);
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 1) chk("sweep_rvalid_low", {23'd0, rvalid, rd}, {23'd0, 1'b0, 8'hFF});
    end while (busy && cnt < 40);
    chk("clr_sweep_len", 32'(cnt), 16);
    chk("sweep_end_rvalid", 32'(rvalid), 0);
    drive(0, 0, 0, 0, 1, 7);
    step();
    chk("post_clr_rd7", {23'd0, rvalid, rd}, {23'd0, 1'b1, 8'h00});
    drive(0, 0, 0, 0, 1, 2);
    step();
    chk("post_clr_rd2", 32'(rd), 0);

    // Async reset mid-read, then mid-sweep at pointer 9
    drive(0, 1, 4, 8'h4B, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 4);
    step();
    chk("pre_rst_read", {23'd0, rvalid, rd}, {23'd0, 1'b1, 8'h4B});
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid_async", 32'(rvalid), 0);
    chk("rst_rd_async", 32'(rd), 0);
    chk("rst_busy_async", 32'(busy), 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("mid_sweep_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midsweep_rst_busy", 32'(busy), 1);
    chk("midsweep_rst_rvalid", 32'(rvalid), 0);
    step();
    rst_n = 1'b1;
    measure_busy(c16, c12);
    chk("restart_sweep_16", 32'(c16), 16);
    chk("restart_sweep_12", 32'(c12), 12);

    // DEPTH=12 boundary behaviour
    drive(0, 1, 11, 8'h99, 0, 0);
    step();
    drive(0, 1, 13, 8'hAB, 1, 11);
    step();
    chk("d12_rd11", {23'd0, rvalid12, rd12}, {23'd0, 1'b1, 8'h99});
    drive(0, 0, 0, 0, 1, 13);
    step();
    chk("d12_rd13_oob", {23'd0, rvalid12, rd12}, {23'd0, 1'b1, 8'h00});
    drive(0, 0, 0, 0, 1, 1);
    step();
    chk("d12_rd1_alias", 32'(rd12), 0);
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
